mul_sixteen_seq: RTL

//  Sequential 16x16 -> 32-bit unsigned shift-and-add multiplier for the project3 ALU.

---
 rtl/mul_pkg.sv | 19 +
 rtl/add_sixteen.sv | 14 +
 rtl/mul_sixteen_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state type for the sequential 16x16 shift-and-add multiplier.
package mul_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // A new operation may be accepted in IDLE and in DONE (back-to-back).
  function automatic logic is_ready(input mul_state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/add_sixteen.sv
// Existing 16-bit ripple adder of the project3 ALU: sum, carry out and signed overflow.
module add_sixteen (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carryin,
  output logic [15:0] sum,
  output logic        carryout,
  output logic        overflow
);

  assign {carryout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carryin};
  assign overflow = (a[15] == b[15]) && (sum[15] != a[15]);

endmodule

// File: rtl/mul_sixteen_seq.sv
// Sequential 16x16 -> 32 unsigned shift-and-add multiplier built around add_sixteen.
// Optional MUL_HI_OVF_EN adds an ovf output flagging a non-zero product high half.
module mul_sixteen_seq #(
  parameter int WIDTH       = 16,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef MUL_HI_OVF_EN
  ,
  output logic               ovf
`endif
);

  import mul_pkg::*;

  mul_state_t           state_r;
  mul_state_t           state_nxt_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     mq_r;
  logic [CNT_W-1:0]     count_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 accept_s;
  logic                 zero_s;
  logic [WIDTH-1:0]     add_b_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 cout_s;
  logic                 add_ovf_unused_s;
  logic [WIDTH-1:0]     step_hi_s;
  logic [WIDTH-1:0]     step_mq_s;
`ifdef MUL_HI_OVF_EN
  logic                 ovf_r;
`endif

  add_sixteen u_add (
    .a        (hi_r),
    .b        (add_b_s),
    .carryin  (1'b0),
    .sum      (sum_s),
    .carryout (cout_s),
    .overflow (add_ovf_unused_s)
  );

  assign accept_s = start && is_ready(state_r);
  assign zero_s   = ZERO_BYPASS && ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}}));
  assign add_b_s  = mq_r[0] ? mcand_r : {WIDTH{1'b0}};

  // One shift-and-add step: {carry, sum, mq} shifted right by one.
  assign step_hi_s = {cout_s, sum_s[WIDTH-1:1]};
  assign step_mq_s = {sum_s[0], mq_r[WIDTH-1:1]};

  // Next-state decode for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = zero_s ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_STEP) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      mcand_r   <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      mq_r      <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
`ifdef MUL_HI_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      ready_r <= is_ready(state_nxt_s);
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        mcand_r   <= a;
        hi_r      <= {WIDTH{1'b0}};
        mq_r      <= b;
        count_r   <= {CNT_W{1'b0}};
        product_r <= {(2*WIDTH){1'b0}};
`ifdef MUL_HI_OVF_EN
        ovf_r     <= 1'b0;
`endif
      end else if (state_r == RUN) begin
        hi_r    <= step_hi_s;
        mq_r    <= step_mq_s;
        count_r <= count_r + 5'd1;
        // The 16th step lands directly in the product register.
        if (count_r == LAST_STEP) begin
          product_r <= {step_hi_s, step_mq_s};
`ifdef MUL_HI_OVF_EN
          ovf_r     <= (step_hi_s != {WIDTH{1'b0}});
`endif
        end
      end
    end
  end

  assign ready   = ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
`ifdef MUL_HI_OVF_EN
  assign ovf     = ovf_r;
`endif

endmodule
